sram_sweeper: RTL
=================

# sram_sweeper

Parametrised SRAM sweep engine that sits between control logic (serial command decoder or a fixed self-test FSM) and the `sram_driver` single-access interface. It walks an address range and performs a read sweep, a pattern write, or a write-then-verify pass. Verify mode compares each readback against a regenerated pattern, counts mismatches and records the first failing address. It replaces the hard-coded 8K read loop with a reusable block of configurable width and depth.

## Interface
- `ADDR_W`, 13: SRAM address width.
- `DATA_W`, 8: SRAM data width, 1..16.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high when idle and able to accept a command.
- `cmd_mode` in 2: 0 read sweep, 1 write pattern, 2 write then verify, 3 reserved (treated as 0).
- `cmd_pattern` in 2: 0 address, 1 constant, 2 inverted address, 3 LFSR.
- `cmd_base` in ADDR_W: first address.
- `cmd_last` in ADDR_W: last address, inclusive.
- `cmd_const` in DATA_W: constant value, or LFSR seed.
- `abort` in 1: stop at the next access boundary.
- `mem_ready` in 1: driver idle.
- `mem_start` out 1: one-cycle access strobe.
- `mem_re` out 1: 1 for read, 0 for write.
- `mem_address` out ADDR_W: access address.
- `mem_data_write` out DATA_W: write data.
- `mem_data_read` in DATA_W: read data, valid when `mem_ready` returns high.
- `busy` out 1: command in progress.
- `done` out 1: one-cycle pulse at command end, including abort.
- `err_count` out ADDR_W+1: verify mismatches, saturating.
- `first_err_addr` out ADDR_W: address of the first mismatch.
- `last_read` out DATA_W: most recent read data.

## Operation
- States: IDLE, ISSUE, ACCEPT, COMPLETE, NEXT, DONE.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`, latch all cmd fields.
  - Set addr=`cmd_base`, pass=write for modes 1/2 or read for mode 0.
  - Clear `err_count`, `first_err_addr`, and the internal err_seen flag.
  - Seed the pattern generator, then go to ISSUE.
- ISSUE:
  - Wait for `mem_ready`=1.
  - Pulse `mem_start` for exactly one cycle with `mem_re`/`mem_address`/`mem_data_write` valid.
  - Go to ACCEPT.
- ACCEPT: wait for `mem_ready`=0 (driver accepted), then go to COMPLETE.
- COMPLETE:
  - Wait for `mem_ready`=1.
  - On a read, capture `last_read`.
  - In the verify pass, compare against the pattern. On mismatch, increment `err_count` (saturating at all ones); if this is the first error, load `first_err_addr`.
  - Go to NEXT.
- NEXT:
  - If addr==`cmd_last`: in mode 2 write pass, switch to read pass, set addr=`cmd_base`, reseed, and go to ISSUE; otherwise go to DONE.
  - Else addr+1 (modulo 2^ADDR_W), advance the pattern, and go to ISSUE.
  - If `abort` was seen at any time since ISSUE, go to DONE regardless.
- DONE: pulse `done` for one cycle, then go to IDLE.
- Patterns are indexed by the current address and step:
  - Address pattern: addr[DATA_W-1:0], zero-extended if ADDR_W<DATA_W.
  - Inverted address pattern: the bitwise inverse of the above.
  - Constant pattern: `cmd_const`.
  - LFSR pattern: a 16-bit Fibonacci LFSR with taps 16,14,13,11. Seed is {zeros,`cmd_const`}, forced to 16'h0001 if zero. Data is the low DATA_W bits. The LFSR steps once per NEXT increment.
- Wrap-around: `cmd_last` < `cmd_base` sweeps through the top address to 0, then on to `cmd_last`. `cmd_last`==`cmd_base` performs one access per pass.
- `cmd_valid` while busy is ignored. `abort` while idle is ignored.
- Reset mid-command: all outputs return to their reset values immediately, no `done` pulse is generated, and the partial sweep is discarded.

## Timing
- Reset values: `cmd_ready`=1; `mem_start`=0, `mem_re`=1, `mem_address`=0, `mem_data_write`=0; `busy`=0, `done`=0, `err_count`=0, `first_err_addr`=0, `last_read`=0.
- All outputs are registered.
- Latency:
  - `cmd_valid` accept cycle to first `mem_start`: 1 cycle, if `mem_ready` is already high.
  - Per access: 4 cycles plus driver latency.
  - Last COMPLETE to `done`: 2 cycles.
- `busy` rises the cycle after accept and falls together with the `done` pulse.
- `mem_start` never asserts while `mem_ready`=0.

## Configuration
- `SRAM_SWEEP_LFSR_EN`:
  - Defined: the LFSR generator is built and pattern 3 selects LFSR data.
  - Undefined: no LFSR logic is built and pattern 3 behaves exactly as pattern 0 (address).

## Structure
- Package `sram_sweep_pkg`: mode codes, pattern codes, state encoding, LFSR taps, and the default seed 16'h0001.
- Sub-module `sram_sweep_pattern`:
  - Inputs: seed/reseed, step strobe, address, pattern select.
  - Output: combinational pattern data.
  - Holds the LFSR register.

## Test plan
- ADDR_W=4, mode 0, base 0, last 15, behavioural SRAM preloaded with addr^8'hA5 -> exactly 16 `mem_start` pulses, all with `mem_re`=1; `last_read`=8'hAA; one `done`; `err_count`=0.
- Mode 2, pattern 0, base 3, last 7 -> 5 writes of 3..7, then 5 reads; `err_count`=0.
- Mode 2, base 3, last 7, SRAM model forcing bit 0 at address 5 -> `err_count`=1, `first_err_addr`=5.
- Mode 1, pattern 1, const 8'h3C, base 14, last 1 (ADDR_W=4) -> writes addresses 14,15,0,1 only.
- Mode 2, pattern 3, seed 0 -> written and read sequences both start at 8'h01 and match; with `SRAM_SWEEP_LFSR_EN` undefined -> data equals the address pattern.
- `abort` mid write pass -> the current access completes, `done` pulses, and no further `mem_start`. Separately, assert `reset` mid-access -> every output is at its reset value in the same cycle.

Source files
------------

// File: rtl/sram_sweep_pkg.sv
// Shared encodings for the SRAM sweep engine: command modes, pattern selects,
// FSM states and the LFSR definition used by the pattern generator.
package sram_sweep_pkg;

    typedef enum logic [1:0] {
        MODE_READ   = 2'd0,
        MODE_WRITE  = 2'd1,
        MODE_VERIFY = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        PAT_ADDR  = 2'd0,
        PAT_CONST = 2'd1,
        PAT_INV   = 2'd2,
        PAT_LFSR  = 2'd3
    } pattern_e;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ISSUE    = 3'd1,
        S_ACCEPT   = 3'd2,
        S_COMPLETE = 3'd3,
        S_NEXT     = 3'd4,
        S_DONE     = 3'd5
    } state_e;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'h0001;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/sram_sweep_pattern.sv
// Pattern generator for the sweep engine; combinational data from address/constant,
// plus an LFSR register built only when SRAM_SWEEP_LFSR_EN is defined.
module sram_sweep_pattern
    import sram_sweep_pkg::*;
#(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] seed,
    input  logic              reseed,
    input  logic              step,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] const_val,
    input  pattern_e          sel,
    output logic [DATA_W-1:0] data
);

    logic [ADDR_W+DATA_W-1:0] addr_ext;
    logic [DATA_W-1:0]        addr_pat;
    logic [DATA_W-1:0]        lfsr_data;

    // Zero-extend then truncate so any ADDR_W/DATA_W ratio works.
    assign addr_ext = {{DATA_W{1'b0}}, addr};
    assign addr_pat = addr_ext[DATA_W-1:0];

`ifdef SRAM_SWEEP_LFSR_EN
    logic [DATA_W+15:0] seed_wide;
    logic [15:0]        seed_ext;
    logic [15:0]        lfsr_q;

    assign seed_wide = {16'h0000, seed};
    assign seed_ext  = seed_wide[15:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else if (reseed) begin
            lfsr_q <= (seed_ext == 16'h0000) ? LFSR_SEED : seed_ext;
        end else if (step) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign lfsr_data = lfsr_q[DATA_W-1:0];
`else
    logic unused_lfsr_inputs;
    assign unused_lfsr_inputs = ^{clk, reset, seed, reseed, step};
    assign lfsr_data          = addr_pat;
`endif

    always_comb begin
        data = addr_pat;
        case (sel)
            PAT_ADDR:  data = addr_pat;
            PAT_CONST: data = const_val;
            PAT_INV:   data = ~addr_pat;
            PAT_LFSR:  data = lfsr_data;
            default:   data = addr_pat;
        endcase
    end

endmodule

// File: rtl/sram_sweeper.sv
// SRAM sweep engine: read sweep, pattern write, or write-then-verify over an
// inclusive, wrapping address range. LFSR pattern built under SRAM_SWEEP_LFSR_EN.
module sram_sweeper
    import sram_sweep_pkg::*;
#(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_mode,
    input  logic [1:0]        cmd_pattern,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [ADDR_W-1:0] cmd_last,
    input  logic [DATA_W-1:0] cmd_const,
    input  logic              abort,
    input  logic              mem_ready,
    output logic              mem_start,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_write,
    input  logic [DATA_W-1:0] mem_data_read,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] last_read,
    output logic [2:0]        state_dbg
);

    // Handshakes: a command is taken on a cycle where cmd_valid && cmd_ready;
    // an access is one mem_start pulse, accepted when mem_ready falls and
    // finished when mem_ready returns high with read data valid.

    state_e            state, state_n;
    mode_e             mode_q;
    pattern_e          pat_q;
    logic [ADDR_W-1:0] addr_q, base_q, last_q;
    logic [DATA_W-1:0] const_q, pat_data, seed_sel;
    logic              pass_rd_q, err_seen_q, abort_seen_q;
    logic              accept, abort_any, at_last, write_pass_end;
    logic              swap_pass, advance, reseed, fire, finish, mismatch;

    assign accept         = (state == S_IDLE) && cmd_valid;
    assign abort_any      = abort_seen_q || abort;
    assign at_last        = (addr_q == last_q);
    assign write_pass_end = (mode_q == MODE_VERIFY) && !pass_rd_q;
    assign swap_pass      = (state == S_NEXT) && !abort_any && at_last && write_pass_end;
    assign advance        = (state == S_NEXT) && !abort_any && !at_last;
    assign reseed         = accept || swap_pass;
    assign seed_sel       = accept ? cmd_const : const_q;
    assign fire           = (state == S_ISSUE) && mem_ready;
    assign finish         = (state == S_COMPLETE) && mem_ready;
    assign mismatch       = finish && pass_rd_q && (mode_q == MODE_VERIFY) &&
                            (mem_data_read != pat_data);
    assign state_dbg      = state;

    sram_sweep_pattern #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_pattern (
        .clk       (clk),
        .reset     (reset),
        .seed      (seed_sel),
        .reseed    (reseed),
        .step      (advance),
        .addr      (addr_q),
        .const_val (const_q),
        .sel       (pat_q),
        .data      (pat_data)
    );

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:     if (cmd_valid)  state_n = S_ISSUE;
            S_ISSUE:    if (mem_ready)  state_n = S_ACCEPT;
            S_ACCEPT:   if (!mem_ready) state_n = S_COMPLETE;
            S_COMPLETE: if (mem_ready)  state_n = S_NEXT;
            S_NEXT: begin
                if (abort_any || (at_last && !write_pass_end)) state_n = S_DONE;
                else                                            state_n = S_ISSUE;
            end
            S_DONE:     state_n = S_IDLE;
            default:    state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            cmd_ready      <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
            mem_start      <= 1'b0;
            mem_re         <= 1'b1;
            mem_address    <= '0;
            mem_data_write <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
            last_read      <= '0;
            mode_q         <= MODE_READ;
            pat_q          <= PAT_ADDR;
            addr_q         <= '0;
            base_q         <= '0;
            last_q         <= '0;
            const_q        <= '0;
            pass_rd_q      <= 1'b1;
            err_seen_q     <= 1'b0;
            abort_seen_q   <= 1'b0;
        end else begin
            state     <= state_n;
            // Status outputs are derived from the next state so they are registered.
            cmd_ready <= (state_n == S_IDLE);
            busy      <= (state_n != S_IDLE) && (state_n != S_DONE);
            done      <= (state_n == S_DONE);
            mem_start <= fire;

            if (accept) begin
                mode_q         <= (cmd_mode == MODE_RSVD) ? MODE_READ : mode_e'(cmd_mode);
                pat_q          <= pattern_e'(cmd_pattern);
                base_q         <= cmd_base;
                last_q         <= cmd_last;
                const_q        <= cmd_const;
                addr_q         <= cmd_base;
                pass_rd_q      <= (cmd_mode == MODE_READ) || (cmd_mode == MODE_RSVD);
                err_count      <= '0;
                first_err_addr <= '0;
                err_seen_q     <= 1'b0;
                abort_seen_q   <= 1'b0;
            end else if (abort && (state != S_IDLE)) begin
                abort_seen_q <= 1'b1;
            end

            if (fire) begin
                mem_re         <= pass_rd_q;
                mem_address    <= addr_q;
                mem_data_write <= pat_data;
            end

            if (finish && pass_rd_q) last_read <= mem_data_read;

            if (mismatch) begin
                if (err_count != '1) err_count <= err_count + 1'b1;
                if (!err_seen_q) begin
                    first_err_addr <= addr_q;
                    err_seen_q     <= 1'b1;
                end
            end

            if (swap_pass) begin
                pass_rd_q <= 1'b1;
                addr_q    <= base_q;
            end else if (advance) begin
                addr_q <= addr_q + 1'b1;
            end
        end
    end

endmodule
